output_buffer_packer: RTL and testbench

- Parametrised successor to the single-word output buffer stage.
- Accepts one adder result per `inner_start` pulse and packs PAR_WRITE results into one buffer commit.
- Stores up to DEPTH words in a circular buffer and drains PAR_READ words per read.
- Sits between the accumulator (`add_reg_out`) and the result reader; back-pressures the datapath via `stall_output_buffer`.

---
 rtl/output_buffer_packer_if.sv | 32 +++
 rtl/output_buffer_packer.sv | 129 ++++++++++++
 tb/tb_output_buffer_packer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/output_buffer_packer_if.sv
// Bus between the accumulator/result reader and output_buffer_packer.
// The slave modport is the packer; the master modport is the datapath/reader side.
interface output_buffer_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_READ   = 1,
  parameter int DEPTH      = 8
);
  logic                           inner_start;
  logic                           last_in;
  logic [DATA_WIDTH-1:0]          add_reg_out;
  logic                           read_buffer_result;
  logic [PAR_READ*DATA_WIDTH-1:0] buffer_res_out;
  logic                           buffer_valid;
  logic                           par_done;
  logic                           stall_output_buffer;
  logic                           full;
  logic                           empty;
  logic [$clog2(DEPTH+1)-1:0]     level;
  logic                           err;

  modport slave (
    input  inner_start, last_in, add_reg_out, read_buffer_result,
    output buffer_res_out, buffer_valid, par_done, stall_output_buffer,
           full, empty, level, err
  );

  modport master (
    output inner_start, last_in, add_reg_out, read_buffer_result,
    input  buffer_res_out, buffer_valid, par_done, stall_output_buffer,
           full, empty, level, err
  );
endinterface

// File: rtl/output_buffer_packer.sv
// Packs PAR_WRITE results per commit into a circular buffer, drains PAR_READ words per read.
// Define OUTPUT_BUFFER_ERR_EN to build the sticky protocol-error flag (otherwise err is 0).
module output_buffer_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_WRITE  = 2,
  parameter int PAR_READ   = 1,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output_buffer_packer_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [DATA_WIDTH-1:0] r_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] r_pack [PAR_WRITE];
  logic [DATA_WIDTH-1:0] w_word [PAR_WRITE];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_nxt;
  logic [CNT_W-1:0] r_pack_cnt;
  logic [CNT_W-1:0] w_lane;
  logic [0:0]       r_state;
  logic             r_par_done;
  logic             w_stall;
  logic             w_valid;
  logic             w_acc;
  logic             w_commit;
  logic             w_pop;

  // Stall and valid look only at the registered level; a same-cycle read does not relieve stall.
  assign w_stall  = (LVL_W'(DEPTH) - r_level) < LVL_W'(PAR_WRITE);
  assign w_valid  = r_level >= LVL_W'(PAR_READ);
  assign w_acc    = bus.inner_start && !w_stall;
  assign w_lane   = (r_state == ST_IDLE) ? '0 : r_pack_cnt;
  assign w_commit = w_acc && ((w_lane == CNT_W'(PAR_WRITE - 1)) || bus.last_in);
  assign w_pop    = bus.read_buffer_result && w_valid;

  assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - PAR_WRITE)) ? '0 : r_wr_ptr + PTR_W'(PAR_WRITE);
  assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - PAR_READ))  ? '0 : r_rd_ptr + PTR_W'(PAR_READ);
  assign w_level_nxt  = r_level + (w_commit ? LVL_W'(PAR_WRITE) : '0) - (w_pop ? LVL_W'(PAR_READ) : '0);

  // Commit image: already packed lanes, the incoming word, zeros in the lanes a flush leaves empty.
  always_comb begin
    for (int l = 0; l < PAR_WRITE; l++) begin
      w_word[l] = '0;
      if (CNT_W'(l) < w_lane)
        w_word[l] = r_pack[l];
      else if (CNT_W'(l) == w_lane)
        w_word[l] = bus.add_reg_out;
    end
  end

  always_comb begin
    bus.buffer_res_out = '0;
    for (int l = 0; l < PAR_READ; l++)
      bus.buffer_res_out[l*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rd_ptr + PTR_W'(l)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_pack_cnt <= '0;
      r_state    <= ST_IDLE;
      r_par_done <= 1'b0;
    end else begin
      r_par_done <= w_commit;
      r_level    <= w_level_nxt;
      if (w_commit) begin
        r_wr_ptr   <= w_wr_ptr_nxt;
        r_pack_cnt <= '0;
        r_state    <= ST_IDLE;
      end else if (w_acc) begin
        r_pack_cnt <= w_lane + CNT_W'(1);
        r_state    <= ST_FILL;
      end
      if (w_pop)
        r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Storage and pack lanes carry data only and are left out of reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int l = 0; l < PAR_WRITE; l++)
        r_mem[r_wr_ptr + PTR_W'(l)] <= w_word[l];
    end
    if (w_acc && !w_commit) begin
      for (int l = 0; l < PAR_WRITE; l++)
        if (w_lane == CNT_W'(l))
          r_pack[l] <= bus.add_reg_out;
    end
  end

  assign bus.buffer_valid        = w_valid;
  assign bus.par_done            = r_par_done;
  assign bus.stall_output_buffer = w_stall;
  assign bus.full                = (r_level == LVL_W'(DEPTH));
  assign bus.empty               = (r_level == '0);
  assign bus.level               = r_level;

`ifdef OUTPUT_BUFFER_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if ((bus.inner_start && w_stall) || (bus.read_buffer_result && !w_valid))
      r_err <= 1'b1;
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_output_buffer_packer.sv
// Scoreboard bench for output_buffer_packer (DATA_WIDTH=16, PAR_WRITE=2, PAR_READ=1, DEPTH=8).
// Expected read words are queued at issue time; a negedge monitor pops and compares on each read.
module tb_output_buffer_packer;

  localparam int DW = 16;
`ifdef OUTPUT_BUFFER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [DW-1:0] exp_q[$];

  output_buffer_packer_if #(.DATA_WIDTH(DW), .PAR_READ(1), .DEPTH(8)) bus ();

  output_buffer_packer #(
    .DATA_WIDTH(DW), .PAR_WRITE(2), .PAR_READ(1), .DEPTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic last);
    bus.inner_start = 1'b1;
    bus.last_in     = last;
    bus.add_reg_out = d;
  endtask

  task automatic idle_in();
    bus.inner_start        = 1'b0;
    bus.last_in            = 1'b0;
    bus.add_reg_out        = '0;
    bus.read_buffer_result = 1'b0;
  endtask

  task automatic read_n(input int n);
    bus.read_buffer_result = 1'b1;
    repeat (n) tick();
    bus.read_buffer_result = 1'b0;
  endtask

  // Monitor: every accepted read must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.read_buffer_result && bus.buffer_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read_unexpected actual=0x%0h required=no_data", bus.buffer_res_out);
      end else begin
        chk("read_data", 32'(bus.buffer_res_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_err;
    int   k;
    idle_in();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_stall", 32'(bus.stall_output_buffer), 0);
    chk("rst_par_done", 32'(bus.par_done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_valid", 32'(bus.buffer_valid), 0);

    // Two results packed into one commit.
    push_word(16'h0011, 1'b0); exp_q.push_back(16'h0011);
    tick();
    chk("pack_no_early_commit", 32'(bus.level), 0);
    push_word(16'h0022, 1'b0); exp_q.push_back(16'h0022);
    tick();
    idle_in();
    chk("pack_par_done", 32'(bus.par_done), 1);
    chk("pack_level", 32'(bus.level), 2);
    tick();
    chk("pack_par_done_pulse", 32'(bus.par_done), 0);
    read_n(2);
    chk("pack_drained_empty", 32'(bus.empty), 1);

    // Partial pack flushed by last_in; empty lane reads as zero.
    push_word(16'h00AB, 1'b1);
    exp_q.push_back(16'h00AB); exp_q.push_back(16'h0000);
    tick();
    idle_in();
    chk("flush_par_done", 32'(bus.par_done), 1);
    chk("flush_level", 32'(bus.level), 2);
    read_n(2);
    chk("flush_empty", 32'(bus.empty), 1);

    // Fill to DEPTH, then an ignored write under stall.
    for (int i = 0; i < 8; i++) begin
      push_word(16'(16'h0101 + i), 1'b0);
      exp_q.push_back(16'(16'h0101 + i));
      tick();
    end
    idle_in();
    chk("full_level", 32'(bus.level), 8);
    chk("full_flag", 32'(bus.full), 1);
    chk("full_stall", 32'(bus.stall_output_buffer), 1);
    push_word(16'h0099, 1'b0);
    tick();
    idle_in();
    exp_err = ERR_EN;
    chk("stall_ignored_level", 32'(bus.level), 8);
    chk("stall_err", 32'(bus.err), 32'(exp_err));
    bus.read_buffer_result = 1'b1;
    tick();
    chk("stall_after_1_read", 32'(bus.stall_output_buffer), 1);
    chk("level_after_1_read", 32'(bus.level), 7);
    tick();
    bus.read_buffer_result = 1'b0;
    chk("stall_after_2_reads", 32'(bus.stall_output_buffer), 0);
    chk("level_after_2_reads", 32'(bus.level), 6);
    read_n(6);
    chk("full_drained_empty", 32'(bus.empty), 1);
    read_n(1);
    chk("read_when_empty_level", 32'(bus.level), 0);
    chk("err_sticky", 32'(bus.err), 32'(exp_err));

    // Streaming 1..20 with a read every cycle data is available; pointers wrap.
    for (int i = 1; i <= 20; i++) begin
      push_word(16'(i), 1'b0);
      exp_q.push_back(16'(i));
      bus.read_buffer_result = bus.buffer_valid;
      tick();
      if (i == 1)
        chk("stream_level", 32'(bus.level), 0);
      else if (i % 2 == 0)
        chk("stream_level", 32'(bus.level), 2);
      else
        chk("stream_level", 32'(bus.level), 1);
    end
    idle_in();
    k = 0;
    while (bus.buffer_valid && k < 40) begin
      bus.read_buffer_result = 1'b1;
      tick();
      k++;
    end
    bus.read_buffer_result = 1'b0;
    chk("stream_empty", 32'(bus.empty), 1);
    chk("stream_all_read", 32'(exp_q.size()), 0);

    // Reset with a partial pack in flight.
    push_word(16'h0055, 1'b0);
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_par_done", 32'(bus.par_done), 0);
    chk("midrst_level", 32'(bus.level), 0);
    chk("midrst_err", 32'(bus.err), 0);
    tick();
    chk("midrst_no_commit", 32'(bus.par_done), 0);
    push_word(16'h0066, 1'b0); exp_q.push_back(16'h0066);
    tick();
    push_word(16'h0077, 1'b0); exp_q.push_back(16'h0077);
    tick();
    idle_in();
    chk("midrst_commit_par_done", 32'(bus.par_done), 1);
    chk("midrst_commit_level", 32'(bus.level), 2);
    read_n(2);
    chk("midrst_empty", 32'(bus.empty), 1);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
